sid_paddle: RTL and testbench

SID_PADDLE -- requirements
Module: sid_paddle

---
 rtl/sid_paddle_if.sv | 9 +
 rtl/sid_paddle.sv | 136 +++++++++++++
 tb/tb_sid_paddle.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sid_paddle_if.sv
// Host-side target handshake for sid_paddle: valid/ready plus the X/Y target pair.
interface sid_paddle_if;
    logic            tgt_valid;
    logic            tgt_ready;
    logic [1:0][7:0] tgt_xy;

    modport master (output tgt_valid, output tgt_xy, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_xy, output tgt_ready);
endinterface

// File: rtl/sid_paddle.sv
// SID POTX/POTY paddle emulator: tracks the SID discharge/measure period and raises
// charged[i] when the measure count reaches the axis target. Option: SID_PADDLE_1351_EN.
package sid;
    typedef logic [1:0] cycle_t;
    typedef struct packed { logic discharge; } pot_o_t;
    typedef struct packed { logic [1:0] charged; } pot_i_t;
endpackage

module sid_paddle #(
    parameter logic [8:0] TIMEOUT = 9'd400
) (
    input  logic          clk,
    input  logic          rst_n,
    input  sid::cycle_t   cycle,
    input  sid::pot_o_t   pot_o,
    output sid::pot_i_t   pot_i,
    sid_paddle_if.slave   tgt,
    output logic          locked,
    output logic          sync_err
);
    localparam int         NUM_AXES = 2;
    localparam logic [8:0] DIS_MAX  = 9'd300;

    typedef enum logic [1:0] {SYNC, DISCHARGE, MEASURE} state_t;

    state_t                        state;
    logic [8:0]                    count;
    logic [8:0]                    dcnt;
    logic [NUM_AXES-1:0]           charged;
    logic [NUM_AXES-1:0]           hit;
    logic [NUM_AXES-1:0][7:0]      active;
    logic [NUM_AXES-1:0][7:0]      pending;
    logic [NUM_AXES-1:0][7:0]      pend_in;
    logic                          pending_full;
    logic                          tick;
    logic                          accept;
    logic                          transfer;

    assign tick           = (cycle == sid::cycle_t'(1));
    assign accept         = tgt.tgt_valid & ~pending_full;
    assign tgt.tgt_ready  = ~pending_full;
    assign transfer       = tick & pot_o.discharge & (state == MEASURE);
    assign pot_i.charged  = charged;

    // count is held at 0 through DISCHARGE, so the entering MEASURE tick compares against 0.
    for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
        assign hit[g] = ~count[8] & (count[7:0] == active[g]);
    end

`ifdef SID_PADDLE_1351_EN
    logic [NUM_AXES-1:0][5:0] pos;
    logic [NUM_AXES-1:0][5:0] pos_nxt;

    for (genvar g = 0; g < NUM_AXES; g++) begin : g_pos
        assign pos_nxt[g] = pos[g] + tgt.tgt_xy[g][5:0];
        assign pend_in[g] = {1'b0, pos_nxt[g], 1'b0} + 8'h40;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      pos <= '0;
        else if (accept) pos <= pos_nxt;
    end
`else
    assign pend_in = tgt.tgt_xy;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SYNC;
            count        <= '0;
            dcnt         <= '0;
            charged      <= '0;
            locked       <= 1'b0;
            sync_err     <= 1'b0;
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (tick) begin
                case (state)
                    SYNC: begin
                        if (pot_o.discharge) begin
                            state   <= DISCHARGE;
                            dcnt    <= 9'd1;
                            count   <= '0;
                            charged <= '0;
                        end
                    end
                    DISCHARGE: begin
                        if (pot_o.discharge) begin
                            if (dcnt == DIS_MAX) begin
                                state    <= SYNC;
                                locked   <= 1'b0;
                                sync_err <= 1'b1;
                            end else begin
                                dcnt <= dcnt + 9'd1;
                            end
                        end else begin
                            state   <= MEASURE;
                            locked  <= 1'b1;
                            charged <= hit;
                            count   <= count + 9'd1;
                        end
                    end
                    MEASURE: begin
                        if (pot_o.discharge) begin
                            state   <= DISCHARGE;
                            dcnt    <= 9'd1;
                            count   <= '0;
                            charged <= '0;
                            if (pending_full) active <= pending;
                        end else if (count == TIMEOUT - 9'd1) begin
                            state    <= SYNC;
                            count    <= '0;
                            charged  <= '0;
                            locked   <= 1'b0;
                            sync_err <= 1'b1;
                        end else begin
                            charged <= charged | hit;
                            count   <= count + 9'd1;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
            // Transfer drains pending before a same-clk accept refills it.
            if (accept) begin
                pending      <= pend_in;
                pending_full <= 1'b1;
            end else if (transfer) begin
                pending_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sid_paddle.sv
// Bench for sid_paddle: run-length reference model checked every clk, plus literal pins.
module tb_sid_paddle;
    localparam int TMO = 400;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    sid::cycle_t  cycle = '0;
    sid::pot_o_t  pot_o = '0;
    sid::pot_i_t  pot_i;
    logic         locked;
    logic         sync_err;
    int           n_checks = 0;
    int           n_errors = 0;

    sid_paddle_if tgt();

    sid_paddle dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cycle    (cycle),
        .pot_o    (pot_o),
        .pot_i    (pot_i),
        .tgt      (tgt),
        .locked   (locked),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = waiting for sync, 1 = discharging, 2 = measuring.
    int              m_ph = 0;
    int              hi_run = 0;
    int              lo_run = 0;
    logic            m_locked = 1'b0;
    logic            m_err = 1'b0;
    logic            m_full = 1'b0;
    logic [1:0][7:0] m_act = '0;
    logic [1:0][7:0] m_pend = '0;
    int              m_pos [2] = '{0, 0};
    logic            started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_charged();
        logic [1:0] r;
        r = '0;
        // Counts 0..lo_run-1 have been seen this period; the target hits if within that range.
        for (int i = 0; i < 2; i++)
            if (m_ph == 2 && lo_run >= int'(m_act[i]) + 1) r[i] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        logic rdy;
        started = 1'b1;
        if (!rst_n) begin
            m_ph = 0; hi_run = 0; lo_run = 0;
            m_locked = 0; m_err = 0; m_full = 0;
            m_act = '0; m_pend = '0; m_pos = '{0, 0};
        end else begin
            rdy   = !m_full;
            m_err = 1'b0;
            if (cycle == 2'd1) begin
                if (pot_o.discharge) begin
                    if (m_ph == 2) begin
                        if (m_full) m_act = m_pend;
                        m_full = 1'b0;
                        m_ph = 1; hi_run = 1;
                    end else if (m_ph == 0) begin
                        m_ph = 1; hi_run = 1;
                    end else begin
                        hi_run++;
                        if (hi_run > 300) begin m_ph = 0; m_locked = 0; m_err = 1; end
                    end
                end else begin
                    if (m_ph == 1) begin
                        m_ph = 2; lo_run = 1; m_locked = 1;
                    end else if (m_ph == 2) begin
                        lo_run++;
                        if (lo_run >= TMO) begin m_ph = 0; m_locked = 0; m_err = 1; end
                    end
                end
            end
            if (tgt.tgt_valid && rdy) begin
                for (int i = 0; i < 2; i++) begin
`ifdef SID_PADDLE_1351_EN
                    m_pos[i]  = (m_pos[i] + int'($signed(tgt.tgt_xy[i]))) & 63;
                    m_pend[i] = 8'(2 * m_pos[i] + 64);
`else
                    m_pend[i] = tgt.tgt_xy[i];
`endif
                end
                m_full = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
            check("charged", 32'(pot_i.charged), 32'(exp_charged()));
            check("locked", 32'(locked), 32'(m_locked));
            check("sync_err", 32'(sync_err), 32'(m_err));
            check("tgt_ready", 32'(tgt.tgt_ready), 32'(!m_full));
        end
    end

    task automatic tick(input logic d, input int n);
        for (int k = 0; k < n; k++) begin
            cycle = 2'd1; pot_o.discharge = d;
            @(negedge clk);
            cycle = 2'd2;
            @(negedge clk);
        end
    endtask

    task automatic set_tgt(input logic [7:0] x, input logic [7:0] y);
        tgt.tgt_valid = 1'b1;
        tgt.tgt_xy[0] = x;
        tgt.tgt_xy[1] = y;
        @(negedge clk);
        tgt.tgt_valid = 1'b0;
    endtask

    initial begin
        tgt.tgt_valid = 1'b0;
        tgt.tgt_xy    = '0;
        repeat (3) @(negedge clk);
        check("rst_charged", 32'(pot_i.charged), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        check("rst_ready", 32'(tgt.tgt_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef SID_PADDLE_1351_EN
        set_tgt(8'h00, 8'h80);
        check("ready_after_accept", 32'(tgt.tgt_ready), 0);
        tick(1, 256);
        check("unlocked_in_first_discharge", 32'(locked), 0);
        tick(0, 1);
        check("locked_first_measure", 32'(locked), 1);
        check("first_period_active0", 32'(pot_i.charged), 32'h3);
        tick(0, 255);
        tick(1, 1);
        check("clear_on_discharge", 32'(pot_i.charged), 0);
        check("ready_after_transfer", 32'(tgt.tgt_ready), 1);
        tick(1, 255);
        tick(0, 1);
        check("x00_first_tick", 32'(pot_i.charged), 32'h1);
        tick(0, 127);
        check("y80_not_yet", 32'(pot_i.charged), 32'h1);
        tick(0, 1);
        check("y80_at_128", 32'(pot_i.charged), 32'h3);
        tick(0, 127);

        tick(1, 256);
        tick(0, 50);
        set_tgt(8'h10, 8'hFF);
        check("ready_low_mid_measure", 32'(tgt.tgt_ready), 0);
        tick(0, 206);
        check("old_target_kept", 32'(pot_i.charged), 32'h3);
        check("ready_low_until_edge", 32'(tgt.tgt_ready), 0);
        tick(1, 1);
        check("ready_after_edge", 32'(tgt.tgt_ready), 1);
        tick(1, 255);
        tick(0, 16);
        check("x10_before_16", 32'(pot_i.charged), 0);
        tick(0, 1);
        check("x10_at_16", 32'(pot_i.charged), 32'h1);
        tick(0, 238);
        check("yff_before_255", 32'(pot_i.charged), 32'h1);
        tick(0, 1);
        check("yff_at_255", 32'(pot_i.charged), 32'h3);
        tick(1, 1);
        check("ff_clear_on_rise", 32'(pot_i.charged), 0);

        tick(1, 255);
        tick(0, 256);
        cycle = 2'd1; pot_o.discharge = 1'b1;
        tgt.tgt_valid = 1'b1; tgt.tgt_xy[0] = 8'h20; tgt.tgt_xy[1] = 8'h30;
        @(negedge clk);
        tgt.tgt_valid = 1'b0; cycle = 2'd2;
        @(negedge clk);
        check("same_clk_ready", 32'(tgt.tgt_ready), 0);
        tick(1, 255);
        tick(0, 16);
        check("same_clk_old_active", 32'(pot_i.charged), 0);
        tick(0, 1);
        check("same_clk_old_active16", 32'(pot_i.charged), 32'h1);
        tick(0, 239);
        tick(1, 1);
        check("same_clk_drained", 32'(tgt.tgt_ready), 1);
        tick(1, 255);
        tick(0, 32);
        check("x20_before_32", 32'(pot_i.charged), 0);
        tick(0, 1);
        check("x20_at_32", 32'(pot_i.charged), 32'h1);
        tick(0, 16);
        check("y30_at_48", 32'(pot_i.charged), 32'h3);
        tick(0, 207);
`else
        set_tgt(8'h03, 8'h00);
        tick(1, 256);
        tick(0, 256);
        tick(1, 1);
        set_tgt(8'hFB, 8'h00);
        check("model_pos_x", 32'(m_pos[0]), 62);
        check("model_pend_x", 32'(m_pend[0]), 32'hBC);
        check("ready_after_delta", 32'(tgt.tgt_ready), 0);
        tick(1, 255);
        tick(0, 256);
        tick(1, 1);
        tick(1, 255);
        tick(0, 65);
        check("y40_at_64", 32'(pot_i.charged), 32'h2);
        tick(0, 123);
        check("xbc_before_188", 32'(pot_i.charged), 32'h2);
        tick(0, 1);
        check("xbc_at_188", 32'(pot_i.charged), 32'h3);
        tick(0, 67);
`endif

        tick(1, 256);
        tick(0, 399);
        check("locked_before_timeout", 32'(locked), 1);
        cycle = 2'd1; pot_o.discharge = 1'b0;
        @(negedge clk);
        check("timeout_sync_err", 32'(sync_err), 1);
        check("timeout_unlocked", 32'(locked), 0);
        check("timeout_charged", 32'(pot_i.charged), 0);
        cycle = 2'd2;
        @(negedge clk);
        check("timeout_pulse_once", 32'(sync_err), 0);
        tick(0, 10);
        check("stays_unlocked", 32'(locked), 0);
        tick(1, 256);
        tick(0, 1);
        check("relock", 32'(locked), 1);

        tick(0, 255);
        tick(1, 300);
        check("locked_300_high", 32'(locked), 1);
        cycle = 2'd1; pot_o.discharge = 1'b1;
        @(negedge clk);
        check("stuck_high_sync_err", 32'(sync_err), 1);
        check("stuck_high_unlocked", 32'(locked), 0);
        cycle = 2'd2;
        @(negedge clk);
        tick(1, 5);
        tick(0, 1);
        check("relock_after_high", 32'(locked), 1);

        tick(0, 100);
        set_tgt(8'h55, 8'h66);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_charged", 32'(pot_i.charged), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_sync_err", 32'(sync_err), 0);
        check("midrst_ready", 32'(tgt.tgt_ready), 1);
        rst_n = 1'b1;
        tick(1, 2);
        tick(0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
